// File: rtl/dbus_access.sv
// Data-bus access unit: issues the memory stage's load/store over a valid/addr_ok/data_ok
// bus, stalls the pipeline until completion and drains accepted requests on flush.
module dbus_access #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [3:0]        req_strobe,
  input  logic [DATA_W-1:0] req_data,
  input  logic              advance,
  input  logic              flush,
  output logic              dreq_valid,
  output logic              dreq_write,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] resp_data,
  output logic [DATA_W-1:0] rd,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StDrainReq,
    StDrain
  } state_e;

  state_e              state_q, state_d;
  logic                dreq_write_q;
  logic [ADDR_W-1:0]   dreq_addr_q;
  logic [2:0]          dreq_size_q;
  logic [3:0]          dreq_strobe_q;
  logic [DATA_W-1:0]   dreq_data_q;
  logic [DATA_W-1:0]   rd_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic                latch_req;
  logic                capture_rd;

  always_comb begin
    state_d    = state_q;
    latch_req  = 1'b0;
    capture_rd = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          latch_req = 1'b1;
          stall     = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        stall = 1'b1;
        if (flush) begin
          // An unaccepted request cannot be withdrawn, so it is drained instead.
          if (!addr_ok)      state_d = StDrainReq;
          else if (!data_ok) state_d = StDrain;
          else               state_d = StIdle;
        end else if (addr_ok) begin
          if (data_ok) begin
            capture_rd = 1'b1;
            state_d    = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        if (flush) begin
          state_d = data_ok ? StIdle : StDrain;
        end else if (data_ok) begin
          capture_rd = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        // Result held until the stage advances; the held request is never re-issued.
        if (flush || advance) state_d = StIdle;
      end
      StDrainReq: begin
        stall = 1'b1;
        if (addr_ok) state_d = data_ok ? StIdle : StDrain;
      end
      StDrain: begin
        stall = 1'b1;
        if (data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      dreq_write_q  <= 1'b0;
      dreq_addr_q   <= '0;
      dreq_size_q   <= '0;
      dreq_strobe_q <= '0;
      dreq_data_q   <= '0;
      rd_q          <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        dreq_write_q  <= req_write;
        dreq_addr_q   <= req_addr;
        dreq_size_q   <= req_size;
        dreq_strobe_q <= req_write ? req_strobe : 4'b0000;
        dreq_data_q   <= req_data;
      end
      if (capture_rd && !dreq_write_q) rd_q <= resp_data;
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign dreq_valid   = (state_q == StReq) || (state_q == StDrainReq);
  assign dreq_write   = dreq_write_q;
  assign dreq_addr    = dreq_addr_q;
  assign dreq_size    = dreq_size_q;
  assign dreq_strobe  = dreq_strobe_q;
  assign dreq_data    = dreq_data_q;
  assign rd           = rd_q;
  assign stall_cycles = stall_cnt_q;

  advance_while_stalled: assert property (@(posedge clk) disable iff (reset)
    !(advance && stall));

endmodule

// File: tb/tb_dbus_access.sv
// Self-checking bench for dbus_access: table-driven bus transactions with an rd scoreboard,
// plus directed flush/reset/back-to-back sequences. Counter width shrunk to hit saturation.
module tb_dbus_access;

  localparam int unsigned CntW   = 4;
  localparam int          CntMax = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_data;
  logic        advance, flush;
  logic        dreq_valid, dreq_write;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        addr_ok, data_ok;
  logic [31:0] resp_data;
  logic [31:0] rd;
  logic        stall;
  logic [CntW-1:0] stall_cycles;

  dbus_access #(.DATA_W(32), .ADDR_W(32), .CNT_W(CntW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .advance(advance), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .addr_ok(addr_ok), .data_ok(data_ok), .resp_data(resp_data),
    .rd(rd), .stall(stall), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
    int          addr_dly;
    int          data_dly;
    int          hold;
    logic [31:0] resp;
    logic [3:0]  exp_strobe;
    int          exp_stall;
    logic [31:0] exp_rd;
  } txn_t;

  txn_t        tbl [6];
  logic [31:0] sb_q [$];
  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  logic [31:0] last_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic run_txn(input int idx);
    txn_t        t;
    int          waited;
    int          acc;
    int          n_stall;
    bit          done;
    logic [31:0] exp;
    t = tbl[idx];
    waited = 0; acc = -1; n_stall = 0; done = 1'b0;
    req_valid = 1'b1; req_write = t.write; req_addr = t.addr;
    req_size = t.size; req_strobe = t.strobe; req_data = t.data;
    sb_q.push_back(t.exp_rd);
    for (int c = 0; c < 40 && !done; c++) begin
      addr_ok   = dreq_valid && (acc < 0) && (waited >= t.addr_dly);
      if (addr_ok) acc = 0;
      data_ok   = (acc == t.data_dly);
      resp_data = data_ok ? t.resp : 32'hDEAD_BEEF;
      #4;
      if (stall) n_stall++;
      if (dreq_valid) begin
        chk("dreq_addr", dreq_addr, t.addr);
        chk("dreq_ctl", 32'({dreq_write, dreq_size, dreq_strobe}),
            32'({t.write, t.size, t.exp_strobe}));
        chk("dreq_data", dreq_data, t.data);
      end
      if (c > 0 && !stall) begin
        done = 1'b1;
        addr_ok = 1'b0; data_ok = 1'b0;
        chk("stall_len", 32'(n_stall), 32'(t.exp_stall));
        exp = sb_q.pop_front();
        chk("rd", rd, exp);
        // Stage held: no second handshake and rd must stay put.
        for (int h = 0; h < t.hold; h++) begin
          tick();
          #4;
          chk("hold_dreq_valid", 32'(dreq_valid), 32'(0));
          chk("hold_rd", rd, exp);
        end
        advance = 1'b1; req_valid = 1'b0;
        tick();
        advance = 1'b0;
        exp_cnt = (exp_cnt + t.exp_stall > CntMax) ? CntMax : exp_cnt + t.exp_stall;
        #4;
        chk("stall_cycles", 32'(stall_cycles), 32'(exp_cnt));
        last_rd = exp;
      end else begin
        if (dreq_valid && acc < 0) waited++;
        tick();
        if (acc >= 0) acc++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn%0d_timeout: stall still %0b, required completion", idx, stall);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      req_valid = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 32'h8000_0010, 3'd2, 4'hF,    32'h0,         0, 0, 0,
               32'h1234_5678, 4'h0,    2, 32'h1234_5678};
    tbl[1] = '{1'b1, 32'h0000_0100, 3'd2, 4'b0011, 32'h0000_00AB, 3, 2, 0,
               32'hFFFF_FFFF, 4'b0011, 7, 32'h1234_5678};
    tbl[2] = '{1'b0, 32'h0000_2004, 3'd2, 4'hF,    32'h0,         0, 3, 5,
               32'hCAFE_F00D, 4'h0,    5, 32'hCAFE_F00D};
    tbl[3] = '{1'b0, 32'h0000_3000, 3'd0, 4'h1,    32'h0,         2, 0, 0,
               32'h0000_00FF, 4'h0,    4, 32'h0000_00FF};
    tbl[4] = '{1'b1, 32'h0000_0044, 3'd1, 4'b1100, 32'hFFFF_0000, 1, 1, 0,
               32'h7777_7777, 4'b1100, 4, 32'h0000_00FF};
    tbl[5] = '{1'b0, 32'h0000_0010, 3'd2, 4'b1010, 32'h0,         0, 1, 0,
               32'h55AA_55AA, 4'h0,    3, 32'h55AA_55AA};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_strobe = '0; req_data = '0; advance = 1'b0; flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; resp_data = '0;
    tick(); tick();
    reset = 1'b0;
    #4;
    chk("rst_dreq_valid", 32'(dreq_valid), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    chk("rst_rd", rd, 32'h0);
    chk("rst_stall_cycles", 32'(stall_cycles), 32'(0));
    chk("rst_dreq_addr", dreq_addr, 32'h0);
    tick();

    for (int i = 0; i < 6; i++) run_txn(i);

    // Flush in REQ before addr_ok: request persists until accepted, data discarded.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400; req_size = 3'd2;
    #4; chk("a_idle_stall", 32'(stall), 32'(1)); tick();
    flush = 1'b1; req_valid = 1'b0;
    #4; chk("a_req_valid", 32'(dreq_valid), 32'(1)); tick();
    flush = 1'b0;
    #4; chk("a_drq_valid", 32'(dreq_valid), 32'(1)); chk("a_drq_stall", 32'(stall), 32'(1));
    chk("a_drq_addr", dreq_addr, 32'h400); tick();
    addr_ok = 1'b1;
    #4; chk("a_drq_valid2", 32'(dreq_valid), 32'(1)); tick();
    addr_ok = 1'b0;
    #4; chk("a_drain_valid", 32'(dreq_valid), 32'(0)); chk("a_drain_stall", 32'(stall), 32'(1));
    tick();
    data_ok = 1'b1; resp_data = 32'hBADB_AD00;
    #4; chk("a_drain_stall2", 32'(stall), 32'(1)); tick();
    data_ok = 1'b0;
    #4; chk("a_idle", 32'(stall), 32'(0)); chk("a_rd", rd, last_rd); tick();

    // Flush in WAIT, data_ok two cycles later.
    req_valid = 1'b1; req_addr = 32'h500;
    tick();
    addr_ok = 1'b1; tick();
    addr_ok = 1'b0; flush = 1'b1; req_valid = 1'b0;
    #4; chk("b_wait_stall", 32'(stall), 32'(1)); chk("b_wait_valid", 32'(dreq_valid), 32'(0));
    tick();
    flush = 1'b0;
    #4; chk("b_drain_stall", 32'(stall), 32'(1)); tick();
    data_ok = 1'b1; resp_data = 32'hBADB_AD01;
    #4; chk("b_drain_stall2", 32'(stall), 32'(1)); tick();
    data_ok = 1'b0;
    #4; chk("b_idle", 32'(stall), 32'(0)); chk("b_rd", rd, last_rd); tick();

    // Flush in REQ coinciding with addr_ok & data_ok: straight back to IDLE, data dropped.
    req_valid = 1'b1; req_addr = 32'h540;
    tick();
    addr_ok = 1'b1; data_ok = 1'b1; resp_data = 32'hBADB_AD02; flush = 1'b1; req_valid = 1'b0;
    tick();
    addr_ok = 1'b0; data_ok = 1'b0; flush = 1'b0;
    #4; chk("d_stall", 32'(stall), 32'(0)); chk("d_valid", 32'(dreq_valid), 32'(0));
    chk("d_rd", rd, last_rd); tick();

    // New request visible during DONE->IDLE is only taken the following cycle.
    req_valid = 1'b1; req_addr = 32'h580;
    tick();
    addr_ok = 1'b1; data_ok = 1'b1; resp_data = 32'h1357_9BDF;
    tick();
    addr_ok = 1'b0; data_ok = 1'b0; advance = 1'b1; req_addr = 32'h600;
    #4; chk("e_done_stall", 32'(stall), 32'(0)); tick();
    advance = 1'b0;
    #4; chk("e_idle_stall", 32'(stall), 32'(1)); chk("e_idle_valid", 32'(dreq_valid), 32'(0));
    chk("e_rd", rd, 32'h1357_9BDF); tick();
    #4; chk("e_req_valid", 32'(dreq_valid), 32'(1)); chk("e_req_addr", dreq_addr, 32'h600);

    // Reset while in WAIT.
    addr_ok = 1'b1; tick();
    addr_ok = 1'b0; req_valid = 1'b0; reset = 1'b1;
    #4; chk("c_wait_stall", 32'(stall), 32'(1)); tick();
    reset = 1'b0;
    #4; chk("c_valid", 32'(dreq_valid), 32'(0)); chk("c_stall", 32'(stall), 32'(0));
    chk("c_stall_cycles", 32'(stall_cycles), 32'(0)); chk("c_rd", rd, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
